// File: rtl/ad9634_spi_pkg.sv
// Shared definitions for the AD9634 configuration sequencer.
// Holds the FSM state encoding, the AD9634 register map constants used by the
// sequencer, error codes, and the 24-bit SPI frame builder.
package ad9634_spi_pkg;

  // Sequencer states; 3 bits cover all eight.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SRST  = 3'd1;
  localparam logic [2:0] ST_RWAIT = 3'd2;
  localparam logic [2:0] ST_ID_RD = 3'd3;
  localparam logic [2:0] ST_CFG   = 3'd4;
  localparam logic [2:0] ST_XFER  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  localparam logic [12:0] SPI_CFG     = 13'h000;
  localparam logic [12:0] CHIP_ID_REG = 13'h001;
  localparam logic [12:0] XFER_REG    = 13'h0FF;

  localparam logic [7:0] SOFT_RST_VAL = 8'h3C;
  localparam logic [7:0] XFER_COMMIT  = 8'h01;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ID   = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef struct packed {
    logic        rw;    // 1 = read
    logic [1:0]  w;     // W1:W0, always single-byte
    logic [12:0] addr;
    logic [7:0]  data;  // zero on reads
  } spi_frame_t;

  function automatic logic [23:0] mk_frame(input logic rw, input logic [12:0] addr,
                                           input logic [7:0] data);
    spi_frame_t f;
    f.rw   = rw;
    f.w    = 2'b00;
    f.addr = addr;
    f.data = rw ? 8'h00 : data;
    return f;
  endfunction

endpackage

// File: rtl/ad9634_cfg_rom.sv
// AD9634 configuration table.
// Combinational lookup: idx_i -> {addr_o, data_o}. Entries never target the
// soft-reset (0x000) or transfer (0x0FF) registers; the sequencer owns those.
//  idx_i   in  IDX_W  table index
//  addr_o  out 13     register address
//  data_o  out 8      register value
module ad9634_cfg_rom #(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [12:0]      addr_o,
  output logic [7:0]       data_o
);

  always_comb begin
    addr_o = 13'h008;
    data_o = 8'h00;
    case (32'(idx_i))
      0: begin addr_o = 13'h014; data_o = 8'h01; end  // output mode: twos complement
      1: begin addr_o = 13'h016; data_o = 8'h20; end  // clock phase
      2: begin addr_o = 13'h008; data_o = 8'h00; end  // power modes: normal
      3: begin addr_o = 13'h00D; data_o = 8'h00; end  // test mode off
      4: begin addr_o = 13'h010; data_o = 8'h00; end  // offset adjust
      5: begin addr_o = 13'h015; data_o = 8'h00; end  // output adjust
      6: begin addr_o = 13'h017; data_o = 8'h00; end  // output delay
      7: begin addr_o = 13'h018; data_o = 8'h04; end  // input span
      default: ;
    endcase
  end

endmodule

// File: rtl/ad9634_cfg_sequencer.sv
// AD9634 power-up / on-demand configuration sequencer.
// Soft-resets the chip, waits, verifies the chip ID with bounded retry, writes
// the config table and commits it through the transfer register. Owns the SPI
// frame engine while busy; exactly one frame outstanding at a time.
//  clk, rst_n          clock, async active-low reset
//  start               pulse, accepted when not busy
//  busy/done/error     status; done/error sticky until next start
//  err_code            00 none, 01 ID mismatch, 10 transfer timeout
//  cmd_valid/ready     frame request handshake to SPI engine
//  cmd_data[23:0]      frame {R/W, W1:W0, addr[12:0], data[7:0]}
//  xfer_done, rd_data  frame completion pulse and readback byte
module ad9634_cfg_sequencer import ad9634_spi_pkg::*; #(
  parameter int          NUM_REGS   = 8,
  parameter int          RST_WAIT   = 1000,  // must be >= 1
  parameter logic [7:0]  CHIP_ID    = 8'h79,
  parameter int          ID_RETRIES = 3,
  parameter int          TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [23:0] cmd_data,
  input  logic        xfer_done,
  input  logic [7:0]  rd_data
);

  localparam int IDX_W  = $clog2(NUM_REGS + 1);
  localparam int WAIT_W = $clog2(RST_WAIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int RTY_W  = $clog2(ID_RETRIES + 2);

  logic [2:0]       state_q, state_d;
  logic             wait_q, wait_d;    // 0: issuing frame, 1: awaiting xfer_done
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             done_q, done_d, err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [12:0]      rom_addr;
  logic [7:0]       rom_data;
  logic             accept;

  ad9634_cfg_rom #(.IDX_W(IDX_W)) u_rom (
    .idx_i  (idx_q),
    .addr_o (rom_addr),
    .data_o (rom_data)
  );

  assign accept = vld_q & cmd_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    rty_d   = rty_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // xfer_done is ignored here, so a coincident one cannot disturb restart
        if (start) begin
          state_d = ST_SRST;
          vld_d   = 1'b1;
          wait_d  = 1'b0;
          idx_d   = '0;
          wcnt_d  = '0;
          tmo_d   = '0;
          rty_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      ST_RWAIT: begin
        if (wcnt_q == WAIT_W'(RST_WAIT - 1)) begin
          state_d = ST_ID_RD;
          vld_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: begin  // frame states: SRST, ID_RD, CFG, XFER
        if (!wait_q) begin
          if (accept) begin
            vld_d  = 1'b0;
            wait_d = 1'b1;
            tmo_d  = '0;
          end
        end else if (xfer_done) begin
          wait_d = 1'b0;
          case (state_q)
            ST_SRST: begin
              state_d = ST_RWAIT;
              wcnt_d  = '0;
            end
            // rd_data is only valid alongside xfer_done, so the ID check is
            // made here rather than in a separate state.
            ST_ID_RD: begin
              if (rd_data == CHIP_ID) begin
                state_d = ST_CFG;
                vld_d   = 1'b1;
              end else if (rty_q < RTY_W'(ID_RETRIES)) begin
                rty_d = rty_q + 1'b1;
                vld_d = 1'b1;
              end else begin
                state_d = ST_ERR;
                err_d   = 1'b1;
                code_d  = ERR_ID;
              end
            end
            ST_CFG: begin
              vld_d = 1'b1;
              if (idx_q == IDX_W'(NUM_REGS - 1)) state_d = ST_XFER;
              else                                idx_d   = idx_q + 1'b1;
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          endcase
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = ERR_TMO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 1'b0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      rty_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Frame is a pure function of state/idx, so it is stable for the whole
  // issue phase and returns to zero with the state on reset.
  always_comb begin
    cmd_data = '0;
    case (state_q)
      ST_SRST:  cmd_data = mk_frame(1'b0, SPI_CFG, SOFT_RST_VAL);
      ST_ID_RD: cmd_data = mk_frame(1'b1, CHIP_ID_REG, 8'h00);
      ST_CFG:   cmd_data = mk_frame(1'b0, rom_addr, rom_data);
      ST_XFER:  cmd_data = mk_frame(1'b0, XFER_REG, XFER_COMMIT);
      default:  cmd_data = '0;
    endcase
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign cmd_valid = vld_q;
  assign done      = done_q;
  assign error     = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_ad9634_cfg_sequencer.sv
module tb_ad9634_cfg_sequencer;
  localparam int NREG = 2;
  localparam int RW   = 20;
  localparam int RTY  = 3;
  localparam int TMO  = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmd_ready = 1'b0, xfer_done = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic busy, done, error, cmd_valid;
  logic [1:0] err_code;
  logic [23:0] cmd_data;

  ad9634_cfg_sequencer #(.NUM_REGS(NREG), .RST_WAIT(RW), .CHIP_ID(8'h79),
                         .ID_RETRIES(RTY), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .xfer_done(xfer_done), .rd_data(rd_data));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tbl_addr[NREG] = '{'h014, 'h016};
  int tbl_data[NREG] = '{'h01, 'h20};
  logic [7:0]  ids_plan[RTY+1];
  logic [7:0]  id_q[$];
  logic [23:0] got[$], exp[$];
  bit exp_done, exp_err;
  logic [1:0] exp_code;
  int stab_bad, proto_bad, lat_bad, rw_gap;
  bit ready_always, poke_start, timed_out, aborted;

  // Chip answers nbad wrong IDs then the right one; all_bad never answers right.
  task automatic plan_ids(input int nbad, input bit all_bad);
    id_q.delete();
    for (int i = 0; i <= RTY; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'h79) b = 8'h78;
      ids_plan[i] = (!all_bad && i == nbad) ? 8'h79 : b;
      id_q.push_back(ids_plan[i]);
    end
  endtask

  // Reference: list of frames the sequence must produce and its final status.
  task automatic model_seq();
    bit ok;
    ok = 0;
    exp.delete();
    exp.push_back(24'h00003C);
    for (int i = 0; i <= RTY && !ok; i++) begin
      exp.push_back(24'h800100);
      if (ids_plan[i] == 8'h79) ok = 1;
    end
    if (ok) begin
      for (int r = 0; r < NREG; r++) exp.push_back(24'(tbl_addr[r] * 256 + tbl_data[r]));
      exp.push_back(24'h00FF01);
    end
    exp_done = ok;
    exp_err  = !ok;
    exp_code = ok ? 2'b00 : 2'b01;
  endtask

  // SPI engine stand-in: accepts frames, answers after a random delay and
  // records accepted frames plus protocol violations.
  task automatic run_engine(input int rdy_lo, input logic [23:0] abort_f, input bit use_abort);
    int budget, n, gap;
    logic [23:0] f;
    got.delete();
    stab_bad = 0; proto_bad = 0; lat_bad = 0; rw_gap = -1; timed_out = 0; aborted = 0;
    budget = 3000;
    cmd_ready = ready_always;
    while (budget > 0) begin
      if (!busy) break;
      if (cmd_valid) begin
        f = cmd_data;
        if (use_abort && f == abort_f) begin aborted = 1; break; end
        for (int k = 0; k < rdy_lo; k++) begin
          cmd_ready = 1'b0;
          @(negedge clk); budget--;
          if (cmd_valid !== 1'b1 || cmd_data !== f) stab_bad++;
        end
        if (!ready_always) begin
          cmd_ready = 1'b1; @(negedge clk); budget--; cmd_ready = 1'b0;
        end else begin
          @(negedge clk); budget--;
        end
        got.push_back(f);
        if (cmd_valid !== 1'b0) proto_bad++;
        n = $urandom_range(1, 8);
        for (int k = 0; k < n; k++) begin
          if (poke_start && $urandom_range(0, 1) == 1) start = 1'b1;
          @(negedge clk); budget--; start = 1'b0;
          if (cmd_valid !== 1'b0) proto_bad++;
        end
        if (f[23] && id_q.size() > 0) rd_data = id_q.pop_front();
        else rd_data = 8'($urandom);
        xfer_done = 1'b1; @(negedge clk); budget--; xfer_done = 1'b0; rd_data = 8'($urandom);
        if (f == 24'h00003C) begin
          gap = 0;
          while (cmd_valid !== 1'b1 && gap < RW + 10) begin @(negedge clk); gap++; budget--; end
          rw_gap = gap;
        end else if (busy && cmd_valid !== 1'b1) lat_bad++;
      end else begin
        @(negedge clk); budget--;
      end
    end
    if (budget <= 0) timed_out = 1;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", error); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_code got %b want 00", err_code); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", cmd_valid); end
    checks++; if (cmd_data !== 24'h0) begin errors++; $display("FAIL rst_data got %h want 000000", cmd_data); end
    // Spurious completions in IDLE must not start anything.
    for (int i = 0; i < 3; i++) begin xfer_done = 1'b1; @(negedge clk); xfer_done = 1'b0; @(negedge clk); end
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_spurious valid=%b busy=%b want 0 0", cmd_valid, busy); end
  endtask

  task automatic test_basic();
    ready_always = 1; poke_start = 0;
    plan_ids(0, 0); model_seq();
    pulse_start();
    checks++; if (cmd_valid !== 1'b1 || cmd_data !== 24'h00003C) begin
      errors++; $display("FAIL basic_first valid=%b data=%h want 1 00003c", cmd_valid, cmd_data); end
    run_engine(0, 24'h0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_budget expired want finish"); end
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_frame%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL basic_status done=%b busy=%b err=%b want 1 0 0", done, busy, error); end
    checks++; if (proto_bad != 0 || lat_bad != 0) begin
      errors++; $display("FAIL basic_proto drops=%0d latency=%0d want 0 0", proto_bad, lat_bad); end
    checks++; if (rw_gap < RW || rw_gap > RW + 1) begin
      errors++; $display("FAIL basic_rwait got %0d want %0d", rw_gap, RW); end
  endtask

  task automatic test_ready_stall();
    ready_always = 0; poke_start = 0;
    plan_ids($urandom_range(0, RTY), 0); model_seq();
    pulse_start();
    run_engine(10, 24'h0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_budget expired want finish"); end
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL stall_frame%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (stab_bad != 0 || proto_bad != 0 || lat_bad != 0) begin
      errors++; $display("FAIL stall_stable unstable=%0d drops=%0d latency=%0d want 0", stab_bad, proto_bad, lat_bad); end
    checks++; if (done !== exp_done || error !== exp_err) begin
      errors++; $display("FAIL stall_status done=%b err=%b want %b %b", done, error, exp_done, exp_err); end
  endtask

  task automatic test_id_fail();
    ready_always = $urandom_range(0, 1) == 1; poke_start = 0;
    plan_ids(0, 1); model_seq();
    pulse_start();
    run_engine(0, 24'h0, 0);
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL idfail_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL idfail_frame%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (error !== 1'b1 || err_code !== 2'b01 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idfail_status err=%b code=%b done=%b busy=%b want 1 01 0 0", error, err_code, done, busy); end
  endtask

  task automatic test_timeout();
    int n;
    pulse_start();
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL tmo_issue valid=%b want 1", cmd_valid); end
    cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
    n = 0;
    while (error !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n != TMO) begin errors++; $display("FAIL tmo_cycles got %0d want %0d", n, TMO); end
    checks++; if (err_code !== 2'b10 || cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL tmo_status code=%b valid=%b busy=%b done=%b want 10 0 0 0", err_code, cmd_valid, busy, done); end
  endtask

  task automatic test_spurious_restart();
    // Late completion of the timed-out frame must not revive the sequence.
    xfer_done = 1'b1; @(negedge clk); xfer_done = 1'b0; @(negedge clk);
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b1) begin
      errors++; $display("FAIL err_spurious valid=%b busy=%b err=%b want 0 0 1", cmd_valid, busy, error); end
    ready_always = 0; poke_start = 1;
    plan_ids($urandom_range(0, 1), 0); model_seq();
    pulse_start();
    checks++; if (error !== 1'b0 || err_code !== 2'b00) begin
      errors++; $display("FAIL restart_clear err=%b code=%b want 0 00", error, err_code); end
    run_engine($urandom_range(0, 3), 24'h0, 0);
    poke_start = 0;
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL poke_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL poke_frame%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL poke_done got %b want 1", done); end
    // Restart from DONE with a coincident completion pulse.
    plan_ids(0, 0); model_seq();
    start = 1'b1; xfer_done = 1'b1; @(negedge clk); start = 1'b0; xfer_done = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1 || cmd_valid !== 1'b1 || cmd_data !== 24'h00003C) begin
      errors++; $display("FAIL redo_start done=%b busy=%b valid=%b data=%h want 0 1 1 00003c", done, busy, cmd_valid, cmd_data); end
    run_engine(0, 24'h0, 0);
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL redo_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL redo_frame%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL redo_done done=%b busy=%b want 1 0", done, busy); end
  endtask

  task automatic test_reset_mid();
    ready_always = 0; poke_start = 0;
    plan_ids(0, 0); model_seq();
    pulse_start();
    run_engine(0, 24'(tbl_addr[1] * 256 + tbl_data[1]), 1);
    checks++; if (!aborted) begin errors++; $display("FAIL mid_reach cfg frame 1 not seen"); end
    rst_n = 1'b0; #1;
    checks++; if (cmd_valid !== 1'b0 || cmd_data !== 24'h0 || busy !== 1'b0 || done !== 1'b0 ||
                  error !== 1'b0 || err_code !== 2'b00) begin
      errors++; $display("FAIL mid_reset valid=%b data=%h busy=%b done=%b err=%b code=%b want all 0",
                         cmd_valid, cmd_data, busy, done, error, err_code); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; @(negedge clk);
    plan_ids(0, 0); model_seq();
    pulse_start();
    run_engine(2, 24'h0, 0);
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL replay_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL replay_frame%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL replay_done got %b want 1", done); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_ready_stall();
    test_ready_stall();
    test_id_fail();
    test_timeout();
    test_spurious_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
